// File: rtl/wb_stage_multi.sv
// Multi-lane write-back stage: registers the retiring bundle, drives RF writes and forwarding,
// counts retired instructions and streams a per-instruction debug trace through a small FIFO.
module wb_stage_multi #(
    parameter int LANES     = 2,
    parameter int XLEN      = 64,
    parameter int DBG_DEPTH = 8,
    localparam int LANE_WD  = 1 + 1 + 5 + XLEN + XLEN + 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [5:0]                 stall,
    input  logic [LANES*LANE_WD-1:0]   mem2wb_bus,
    output logic [LANES*(6+XLEN)-1:0]  wb2rf_bus,
    output logic [LANES*(6+XLEN)-1:0]  wb2ex_fwd,
    output logic                       stallreq_wb,
    output logic [63:0]                instret,
    output logic                       trace_ovf,
    output logic [XLEN-1:0]            debug_wb_pc,
    output logic [XLEN/8-1:0]          debug_wb_rf_we,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [XLEN-1:0]            debug_wb_rf_wdata,
    output logic                       debug_wb_valid
);

    localparam int OFF_PC = 32;
    localparam int OFF_WD = 32 + XLEN;
    localparam int OFF_WA = 32 + 2 * XLEN;
    localparam int OFF_WE = 37 + 2 * XLEN;
    localparam int OFF_V  = 38 + 2 * XLEN;
    localparam int RF_W   = 6 + XLEN;
    localparam int ENT_W  = 2 * XLEN + 6;
    localparam int PTR_W  = $clog2(DBG_DEPTH);
    localparam int CNT_W  = $clog2(DBG_DEPTH + 1);

    logic [LANES*LANE_WD-1:0] bundle_q;
    logic [ENT_W-1:0]         trace_mem [DBG_DEPTH];
    logic [PTR_W-1:0]         rd_ptr, wr_ptr;
    logic [CNT_W-1:0]         count;

    logic                     capture, pop, drop;
    logic [CNT_W-1:0]         cap, n_valid, n_enq;
    logic [LANES-1:0]         enq_ok;
    logic [CNT_W-1:0]         enq_off [LANES];
    logic [ENT_W-1:0]         m_entry [LANES];
    logic [LANES-1:0]         we_raw, we_fin;
    logic [4:0]               b_waddr [LANES];
    logic [XLEN-1:0]          b_wdata [LANES];
    logic [ENT_W-1:0]         head;
    logic                     unused_bits;

    assign capture = ~stall[4];
    assign pop     = (count != '0);

    // RF write path from the registered bundle; a younger lane to the same register wins.
    always_comb begin
        wb2rf_bus = '0;
        for (int i = 0; i < LANES; i++) begin
            b_waddr[i] = bundle_q[i*LANE_WD + OFF_WA +: 5];
            b_wdata[i] = bundle_q[i*LANE_WD + OFF_WD +: XLEN];
            we_raw[i]  = bundle_q[i*LANE_WD + OFF_V] & bundle_q[i*LANE_WD + OFF_WE]
                         & (b_waddr[i] != 5'd0);
        end
        for (int i = 0; i < LANES; i++) begin
            we_fin[i] = we_raw[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (we_raw[j] && (b_waddr[j] == b_waddr[i]))
                    we_fin[i] = 1'b0;
            end
            wb2rf_bus[i*RF_W +: RF_W] = {we_fin[i], b_waddr[i], b_wdata[i]};
        end
    end

    assign wb2ex_fwd = wb2rf_bus;

    // Trace enqueue selection; the head slot freed by this edge's pop is reusable.
    always_comb begin
        cap     = CNT_W'(DBG_DEPTH) - count + CNT_W'(pop);
        n_valid = '0;
        n_enq   = '0;
        drop    = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            m_entry[i] = {mem2wb_bus[i*LANE_WD + OFF_PC +: XLEN],
                          mem2wb_bus[i*LANE_WD + OFF_WE] & (mem2wb_bus[i*LANE_WD + OFF_WA +: 5] != 5'd0),
                          mem2wb_bus[i*LANE_WD + OFF_WA +: 5],
                          mem2wb_bus[i*LANE_WD + OFF_WD +: XLEN]};
            enq_ok[i]  = 1'b0;
            enq_off[i] = '0;
            if (mem2wb_bus[i*LANE_WD + OFF_V]) begin
                n_valid = n_valid + CNT_W'(1);
                if (n_enq < cap) begin
                    enq_ok[i]  = 1'b1;
                    enq_off[i] = n_enq;
                    n_enq      = n_enq + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bundle_q  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            instret   <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (!stall[4])
                bundle_q <= mem2wb_bus;
            else if (!stall[5])
                bundle_q <= '0;
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (capture) begin
                wr_ptr  <= wr_ptr + PTR_W'(n_enq);
                instret <= instret + 64'(n_valid);
                if (drop)
                    trace_ovf <= 1'b1;
            end
            count <= count + (capture ? n_enq : '0) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < LANES; i++) begin
                if (enq_ok[i])
                    trace_mem[wr_ptr + PTR_W'(enq_off[i])] <= m_entry[i];
            end
        end
    end

    assign head              = trace_mem[rd_ptr];
    assign debug_wb_valid    = pop;
    assign debug_wb_pc       = pop ? head[XLEN+6 +: XLEN] : '0;
    assign debug_wb_rf_we    = {(XLEN/8){pop & head[XLEN+5]}};
    assign debug_wb_rf_wnum  = pop ? head[XLEN +: 5] : 5'd0;
    assign debug_wb_rf_wdata = pop ? head[XLEN-1:0] : '0;
    assign stallreq_wb       = (CNT_W'(DBG_DEPTH) - count) < CNT_W'(LANES);

    // pc/inst of the registered bundle and the low stall bits have no consumer here.
    always_comb begin
        unused_bits = ^stall[3:0];
        for (int i = 0; i < LANES; i++)
            unused_bits = unused_bits ^ (^bundle_q[i*LANE_WD +: 32+XLEN]) ^ (^mem2wb_bus[i*LANE_WD +: 32]);
    end

endmodule

// File: tb/tb_wb_stage_multi.sv
// Bench for wb_stage_multi: directed scenarios plus random bundles against a queue-based model.
module tb_wb_stage_multi;

    localparam int LANES   = 2;
    localparam int XLEN    = 64;
    localparam int DEPTH   = 8;
    localparam int LANE_WD = 1 + 1 + 5 + XLEN + XLEN + 32;
    localparam int RF_W    = 6 + XLEN;

    typedef struct {
        logic        valid;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] pc;
        logic [31:0] inst;
    } lane_t;

    typedef struct {
        logic [63:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [63:0] wdata;
    } trace_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [5:0]               stall;
    logic [LANES*LANE_WD-1:0] mem2wb_bus;
    logic [LANES*RF_W-1:0]    wb2rf_bus, wb2ex_fwd;
    logic                     stallreq_wb;
    logic [63:0]              instret;
    logic                     trace_ovf;
    logic [XLEN-1:0]          debug_wb_pc;
    logic [XLEN/8-1:0]        debug_wb_rf_we;
    logic [4:0]               debug_wb_rf_wnum;
    logic [XLEN-1:0]          debug_wb_rf_wdata;
    logic                     debug_wb_valid;

    wb_stage_multi #(.LANES(LANES), .XLEN(XLEN), .DBG_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .mem2wb_bus        (mem2wb_bus),
        .wb2rf_bus         (wb2rf_bus),
        .wb2ex_fwd         (wb2ex_fwd),
        .stallreq_wb       (stallreq_wb),
        .instret           (instret),
        .trace_ovf         (trace_ovf),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .debug_wb_valid    (debug_wb_valid)
    );

    always #5 clk = ~clk;

    lane_t       in_l [LANES];
    lane_t       bun_m [LANES];
    trace_t      q [$];
    logic [63:0] m_instret;
    logic        m_ovf;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic lane_t mk(input logic v, input logic we, input logic [4:0] wa,
                                 input logic [63:0] wd, input logic [63:0] pc);
        lane_t l;
        l.valid = v;
        l.rf_we = we;
        l.waddr = wa;
        l.wdata = wd;
        l.pc    = pc;
        l.inst  = $urandom;
        return l;
    endfunction

    function automatic lane_t idle_lane();
        lane_t l;
        l.valid = 1'b0;
        l.rf_we = 1'b0;
        l.waddr = 5'd0;
        l.wdata = 64'd0;
        l.pc    = 64'd0;
        l.inst  = 32'd0;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge: drain one trace entry, then retire the incoming bundle.
    task automatic model_edge(input logic [5:0] st);
        trace_t t;
        if (q.size() > 0)
            void'(q.pop_front());
        if (!st[4]) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_l[i].valid) begin
                    m_instret = m_instret + 64'd1;
                    if (q.size() < DEPTH) begin
                        t.pc    = in_l[i].pc;
                        t.we    = in_l[i].rf_we && (in_l[i].waddr != 5'd0);
                        t.waddr = in_l[i].waddr;
                        t.wdata = in_l[i].wdata;
                        q.push_back(t);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            for (int i = 0; i < LANES; i++) bun_m[i] = in_l[i];
        end else if (!st[5]) begin
            for (int i = 0; i < LANES; i++) bun_m[i] = idle_lane();
        end
    endtask

    task automatic check_all();
        logic [LANES*RF_W-1:0] exp_rf;
        logic                  we;
        exp_rf = '0;
        for (int i = 0; i < LANES; i++) begin
            we = bun_m[i].valid && bun_m[i].rf_we && (bun_m[i].waddr != 5'd0);
            for (int j = i + 1; j < LANES; j++)
                if (bun_m[j].valid && bun_m[j].rf_we && bun_m[j].waddr == bun_m[i].waddr)
                    we = 1'b0;
            exp_rf[i*RF_W +: RF_W] = {we, bun_m[i].waddr, bun_m[i].wdata};
        end
        chk("wb2rf_bus", 256'(wb2rf_bus), 256'(exp_rf));
        chk("wb2ex_fwd", 256'(wb2ex_fwd), 256'(exp_rf));
        chk("instret", 256'(instret), 256'(m_instret));
        chk("trace_ovf", 256'(trace_ovf), 256'(m_ovf));
        chk("stallreq_wb", 256'(stallreq_wb), 256'((DEPTH - q.size()) < LANES));
        chk("debug_wb_valid", 256'(debug_wb_valid), 256'(q.size() > 0));
        if (q.size() > 0) begin
            chk("debug_wb_pc", 256'(debug_wb_pc), 256'(q[0].pc));
            chk("debug_wb_rf_we", 256'(debug_wb_rf_we), 256'({8{q[0].we}}));
            chk("debug_wb_rf_wnum", 256'(debug_wb_rf_wnum), 256'(q[0].waddr));
            chk("debug_wb_rf_wdata", 256'(debug_wb_rf_wdata), 256'(q[0].wdata));
        end else begin
            chk("debug_wb_pc", 256'(debug_wb_pc), 256'(0));
            chk("debug_wb_rf_we", 256'(debug_wb_rf_we), 256'(0));
            chk("debug_wb_rf_wnum", 256'(debug_wb_rf_wnum), 256'(0));
            chk("debug_wb_rf_wdata", 256'(debug_wb_rf_wdata), 256'(0));
        end
    endtask

    task automatic step(input logic [5:0] st);
        @(negedge clk);
        stall = st;
        for (int i = 0; i < LANES; i++)
            mem2wb_bus[i*LANE_WD +: LANE_WD] = {in_l[i].valid, in_l[i].rf_we, in_l[i].waddr,
                                                in_l[i].wdata, in_l[i].pc, in_l[i].inst};
        @(posedge clk);
        model_edge(st);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        for (int i = 0; i < LANES; i++) in_l[i] = idle_lane();
    endtask

    task automatic set_full(input logic [63:0] pc_base);
        for (int i = 0; i < LANES; i++)
            in_l[i] = mk(1'b1, 1'b1, 5'(i + 10), {$urandom, $urandom}, pc_base + 64'(4 * i));
    endtask

    initial begin
        logic [5:0] st;
        rst        = 1'b1;
        stall      = 6'd0;
        mem2wb_bus = '0;
        set_idle();
        for (int i = 0; i < LANES; i++) bun_m[i] = idle_lane();
        m_instret = 64'd0;
        m_ovf     = 1'b0;

        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(6'd0);

        // Basic two-lane retire, then drain over two cycles.
        in_l[0] = mk(1'b1, 1'b1, 5'd5, 64'h11, 64'h100);
        in_l[1] = mk(1'b1, 1'b1, 5'd6, 64'h22, 64'h104);
        step(6'd0);
        chk("instret_after_pair", 256'(instret), 256'(2));
        set_idle();
        step(6'd0);
        chk("second_trace_pc", 256'(debug_wb_pc), 256'(64'h104));
        step(6'd0);

        // Same destination on both lanes.
        in_l[0] = mk(1'b1, 1'b1, 5'd7, 64'hA, 64'h108);
        in_l[1] = mk(1'b1, 1'b1, 5'd7, 64'hB, 64'h10C);
        step(6'd0);
        chk("x7_forward_data", 256'(wb2ex_fwd[RF_W +: RF_W]), 256'({1'b1, 5'd7, 64'hB}));
        set_idle();
        step(6'd0);
        step(6'd0);

        // Write to x0.
        in_l[0] = mk(1'b1, 1'b1, 5'd0, 64'hFF, 64'h110);
        step(6'd0);
        set_idle();
        step(6'd0);

        // Stall behaviour: flush then hold.
        set_full(64'h200);
        step(6'd0);
        set_full(64'h300);
        step(6'b010000);
        set_full(64'h400);
        step(6'd0);
        set_full(64'h500);
        step(6'b110000);
        step(6'b110000);
        set_idle();
        for (int k = 0; k < 6; k++) step(6'd0);

        // Back-to-back full bundles until the trace FIFO overflows.
        for (int k = 0; k < 9; k++) begin
            set_full(64'h1000 + 64'(16 * k));
            step(6'd0);
        end
        chk("ovf_set", 256'(trace_ovf), 256'(1));
        set_idle();
        for (int k = 0; k < 3; k++) step(6'd0);

        // Asynchronous reset with five entries pending.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_instret = 64'd0;
        m_ovf     = 1'b0;
        for (int i = 0; i < LANES; i++) bun_m[i] = idle_lane();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(6'd0);
        step(6'd0);

        // Random bundles and stall patterns.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < LANES; i++)
                in_l[i] = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
            st    = 6'($urandom);
            st[4] = ($urandom_range(0, 3) == 0);
            step(st);
        end
        set_idle();
        for (int k = 0; k < 10; k++) step(6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
